// File: rtl/usb_hid_kbd_report_gen.sv
// HID boot-keyboard report generator: queues key events, batches them into 8-byte press reports, each followed by an all-zero release report.
// Latency: an event pushed into an idle, empty block shows up as ep_valid=1 two cycles after the push edge.
// Backpressure: key_ready drops when the event queue is full; ep_ready low stalls report output with ep_data held.
//
// Ports:
//   clk, usb_rstn                 clock, asynchronous active-low reset
//   key_modifier/key_code         offered key event (keycode 0x00 = modifier-only event)
//   key_valid/key_ready           event handshake; pushed on key_valid && key_ready
//   fifo_level                    number of queued events
//   ep_data/ep_valid/ep_ready     report byte stream towards IN endpoint 0x81
//   report_cnt, drop_cnt          only with USB_HID_KBD_STATS_EN defined: completed press
//                                 reports (wrapping) and refused offer cycles (saturating)

// Generic synchronous FIFO with registered push_rdy and occupancy count.
// Latency: data written on a push is visible at pop_dat from the next cycle.
// Backpressure: push_rdy is low while full; simultaneous push and pop leave the level unchanged.
module usb_hid_kbd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     usb_rstn,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    output logic                     push_rdy,
    output logic                     pop_vld,
    output logic [WIDTH-1:0]         pop_dat,
    input  logic                     pop_rdy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_rdy_q, push_rdy_d;
    logic             push, pop;

    assign push    = push_vld && push_rdy_q;
    assign pop     = pop_rdy && (level_q != '0);
    assign pop_vld = (level_q != '0);
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_rdy = push_rdy_q;
    assign level    = level_q;

    always_comb begin
        // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        push_rdy_d = (level_d != LW'(DEPTH));
    end

    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            push_rdy_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            push_rdy_q <= push_rdy_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

module usb_hid_kbd_report_gen #(
    parameter int FIFO_DEPTH = 8,
    parameter int NKEYS      = 6,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          usb_rstn,
    input  logic [7:0]                    key_modifier,
    input  logic [7:0]                    key_code,
    input  logic                          key_valid,
    output logic                          key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    ep_data,
    output logic                          ep_valid,
    input  logic                          ep_ready
`ifdef USB_HID_KBD_STATS_EN
    ,
    output logic [15:0]                   report_cnt,
    output logic [15:0]                   drop_cnt
`endif
);
    localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GATHER,
        SEND_PRESS,
        GAP_P,
        SEND_REL,
        GAP_R
    } state_t;

    // Event queue: {modifier, keycode}.
    logic        head_vld;
    logic [15:0] head_dat;
    logic        pop;
    logic [7:0]  head_mod, head_code;

    usb_hid_kbd_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .usb_rstn (usb_rstn),
        .push_vld (key_valid),
        .push_dat ({key_modifier, key_code}),
        .push_rdy (key_ready),
        .pop_vld  (head_vld),
        .pop_dat  (head_dat),
        .pop_rdy  (pop),
        .level    (fifo_level)
    );

    assign head_mod  = head_dat[15:8];
    assign head_code = head_dat[7:0];

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      mod_q, mod_d;
    logic [5:0][7:0] keys_q, keys_d;
    logic [7:0]      gap_q, gap_d;
    logic            ep_valid_q, ep_valid_d;
    logic [7:0]      ep_data_q, ep_data_d;

    logic            consume;
    logic            dup;
    logic            can_join;
    logic [2:0]      idx_nxt;
    logic [2:0]      slot;
    logic [7:0]      press_byte;

    assign consume  = ep_valid_q && ep_ready;
    assign ep_valid = ep_valid_q;
    assign ep_data  = ep_data_q;

    // Unused batch slots are held at zero and a joining keycode is never zero,
    // so scanning all slots is equivalent to scanning only the filled ones.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (keys_q[i] == head_code) begin
                dup = 1'b1;
            end
        end
    end

    assign can_join = head_vld && (head_mod == mod_q) && (head_code != 8'h00) &&
                      !dup && (cnt_q < 3'(NKEYS));

    // Byte presented after the current press byte is consumed (idx 1..7).
    always_comb begin
        idx_nxt    = idx_q + 3'd1;
        slot       = idx_nxt - 3'd2;
        press_byte = (idx_nxt < 3'd2) ? 8'h00 : keys_q[slot];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        mod_d      = mod_q;
        keys_d     = keys_q;
        gap_d      = gap_q;
        ep_valid_d = ep_valid_q;
        ep_data_d  = ep_data_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_vld) begin
                    pop       = 1'b1;
                    mod_d     = head_mod;
                    keys_d    = '0;
                    keys_d[0] = head_code;
                    cnt_d     = 3'd1;
                    // A modifier-only event closes the batch immediately.
                    if (head_code == 8'h00) begin
                        state_d    = SEND_PRESS;
                        idx_d      = 3'd0;
                        ep_valid_d = 1'b1;
                        ep_data_d  = head_mod;
                    end else begin
                        state_d = GATHER;
                    end
                end
            end
            GATHER: begin
                if (can_join) begin
                    pop           = 1'b1;
                    keys_d[cnt_q] = head_code;
                    cnt_d         = cnt_q + 3'd1;
                end else begin
                    state_d    = SEND_PRESS;
                    idx_d      = 3'd0;
                    ep_valid_d = 1'b1;
                    ep_data_d  = mod_q;
                end
            end
            SEND_PRESS: begin
                if (consume) begin
                    if (idx_q == 3'd7) begin
                        state_d    = GAP_P;
                        gap_d      = GAP_INIT;
                        ep_valid_d = 1'b0;
                        ep_data_d  = 8'h00;
                    end else begin
                        idx_d     = idx_nxt;
                        ep_data_d = press_byte;
                    end
                end
            end
            GAP_P: begin
                if (gap_q == 8'd0) begin
                    state_d    = SEND_REL;
                    idx_d      = 3'd0;
                    ep_valid_d = 1'b1;
                    ep_data_d  = 8'h00;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            SEND_REL: begin
                if (consume) begin
                    if (idx_q == 3'd7) begin
                        state_d    = GAP_R;
                        gap_d      = GAP_INIT;
                        ep_valid_d = 1'b0;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            GAP_R: begin
                if (gap_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                ep_valid_d = 1'b0;
                ep_data_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= 3'd0;
            mod_q      <= 8'h00;
            keys_q     <= '0;
            gap_q      <= 8'd0;
            ep_valid_q <= 1'b0;
            ep_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            mod_q      <= mod_d;
            keys_q     <= keys_d;
            gap_q      <= gap_d;
            ep_valid_q <= ep_valid_d;
            ep_data_q  <= ep_data_d;
        end
    end

`ifdef USB_HID_KBD_STATS_EN
    logic        press_done;
    logic [15:0] report_cnt_q, report_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign press_done = (state_q == SEND_PRESS) && consume && (idx_q == 3'd7);

    always_comb begin
        report_cnt_d = press_done ? report_cnt_q + 16'd1 : report_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        if (key_valid && !key_ready && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            report_cnt_q <= 16'd0;
            drop_cnt_q   <= 16'd0;
        end else begin
            report_cnt_q <= report_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign report_cnt = report_cnt_q;
    assign drop_cnt   = drop_cnt_q;
`endif
endmodule

// File: tb/tb_usb_hid_kbd_report_gen.sv
// Directed bench for usb_hid_kbd_report_gen (FIFO_DEPTH=4, NKEYS=6, GAP_CYCLES=1).
// Inputs change and outputs are sampled on the falling clock edge.
// Reports are collected as 64-bit words with byte 0 in the most significant byte.
module tb_usb_hid_kbd_report_gen;
    logic       clk = 1'b0;
    logic       usb_rstn = 1'b0;
    logic [7:0] key_modifier = 8'h00;
    logic [7:0] key_code = 8'h00;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [2:0] fifo_level;
    logic [7:0] ep_data;
    logic       ep_valid;
    logic       ep_ready = 1'b1;
`ifdef USB_HID_KBD_STATS_EN
    logic [15:0] report_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    usb_hid_kbd_report_gen #(
        .FIFO_DEPTH (4),
        .NKEYS      (6),
        .GAP_CYCLES (1)
    ) dut (
        .clk          (clk),
        .usb_rstn     (usb_rstn),
        .key_modifier (key_modifier),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .fifo_level   (fifo_level),
        .ep_data      (ep_data),
        .ep_valid     (ep_valid),
        .ep_ready     (ep_ready)
`ifdef USB_HID_KBD_STATS_EN
        ,
        .report_cnt   (report_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Offer one event for one clock; key_valid stays high for back-to-back use.
    task automatic push_ev(input logic [7:0] m, input logic [7:0] c);
        key_modifier = m;
        key_code     = c;
        key_valid    = 1'b1;
        @(negedge clk);
    endtask

    // Collect one 8-byte report. toggle=1 drives ep_ready 1,0,1,0... while valid.
    task automatic get_report(input bit toggle, output logic [63:0] rpt,
                              output bit ok, output bit stable);
        int n;
        int guard;
        bit ph;
        bit hold_chk;
        logic [7:0] held;
        n = 0; guard = 0; ph = 1'b1; hold_chk = 1'b0; held = 8'h00;
        ok = 1'b1; stable = 1'b1; rpt = '0;
        while (!ep_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!ep_valid) begin
            ok = 1'b0;
            ep_ready = 1'b1;
            return;
        end
        while (n < 8 && guard < 200) begin
            if (hold_chk && ep_data !== held) stable = 1'b0;
            hold_chk = 1'b0;
            ep_ready = toggle ? ph : 1'b1;
            if (ep_ready) begin
                rpt = {rpt[55:0], ep_data};
                n++;
            end else begin
                held = ep_data;
                hold_chk = 1'b1;
            end
            @(negedge clk);
            guard++;
            ph = !ph;
            if (n < 8 && !ep_valid) break;
        end
        if (n < 8) ok = 1'b0;
        ep_ready = 1'b1;
    endtask

    // Count low ep_valid cycles starting at the current sample point.
    task automatic count_low(output int lowc);
        lowc = 0;
        while (!ep_valid && lowc < 40) begin
            lowc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        usb_rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ep_valid !== 1'b0 || ep_data !== 8'h00 || fifo_level !== 3'd0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: ep_valid=%b ep_data=%h fifo_level=%0d key_ready=%b, want 0 00 0 1",
                     ep_valid, ep_data, fifo_level, key_ready);
        end
        usb_rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        logic [63:0] r;
        bit ok, st;
        int lat, lowc;
        ep_ready = 1'b1;
        push_ev(8'h02, 8'h04);
        key_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL single_level_after_push: got %0d want 1", fifo_level);
        end
        lat = 1;
        while (!ep_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!ep_valid || lat > 4) begin
            errors++;
            $display("FAIL single_latency: ep_valid after %0d cycles, want <= 4", lat);
        end
        get_report(1'b0, r, ok, st);
        checks++;
        if (!ok || r !== 64'h0200_0400_0000_0000) begin
            errors++;
            $display("FAIL single_press: got %h ok=%0d want 0200040000000000", r, ok);
        end
        count_low(lowc);
        checks++;
        if (lowc != 1) begin
            errors++;
            $display("FAIL single_gap: got %0d low cycles want 1", lowc);
        end
        get_report(1'b0, r, ok, st);
        checks++;
        if (!ok || r !== 64'h0) begin
            errors++;
            $display("FAIL single_release: got %h ok=%0d want 0000000000000000", r, ok);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (fifo_level !== 3'd0 || ep_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: fifo_level=%0d ep_valid=%b want 0 0", fifo_level, ep_valid);
        end
    endtask

    task automatic test_batch;
        logic [63:0] r;
        bit ok, st, seen;
        int lowc;
        push_ev(8'h00, 8'h04);
        push_ev(8'h00, 8'h05);
        push_ev(8'h00, 8'h06);
        key_valid = 1'b0;
        get_report(1'b0, r, ok, st);
        checks++;
        if (!ok || r !== 64'h0000_0405_0600_0000) begin
            errors++;
            $display("FAIL batch_press: got %h ok=%0d want 0000040506000000", r, ok);
        end
        count_low(lowc);
        get_report(1'b0, r, ok, st);
        checks++;
        if (!ok || r !== 64'h0 || lowc != 1) begin
            errors++;
            $display("FAIL batch_release: got %h ok=%0d gap=%0d want 0 ok gap 1", r, ok, lowc);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ep_valid) seen = 1'b1;
        end
        checks++;
        if (seen || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL batch_single_report: extra_valid=%0d fifo_level=%0d want 0 0", seen, fifo_level);
        end
    endtask

    task automatic test_dup_and_modifier;
        logic [63:0] r;
        logic [63:0] exp [3];
        bit ok, st;
        exp[0] = 64'h0000_0400_0000_0000;
        exp[1] = 64'h0000_0400_0000_0000;
        exp[2] = 64'h0100_0700_0000_0000;
        push_ev(8'h00, 8'h04);
        push_ev(8'h00, 8'h04);
        push_ev(8'h01, 8'h07);
        key_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            get_report(1'b0, r, ok, st);
            checks++;
            if (!ok || r !== exp[i]) begin
                errors++;
                $display("FAIL split_press_%0d: got %h ok=%0d want %h", i, r, ok, exp[i]);
            end
            get_report(1'b0, r, ok, st);
            checks++;
            if (!ok || r !== 64'h0) begin
                errors++;
                $display("FAIL split_release_%0d: got %h ok=%0d want 0", i, r, ok);
            end
        end
    endtask

    task automatic test_stall_toggle;
        logic [63:0] r;
        bit ok, st;
        push_ev(8'h00, 8'h1E);
        key_valid = 1'b0;
        get_report(1'b1, r, ok, st);
        checks++;
        if (!ok || r !== 64'h0000_1E00_0000_0000) begin
            errors++;
            $display("FAIL toggle_press: got %h ok=%0d want 00001e0000000000", r, ok);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL toggle_stable: ep_data changed while ep_ready low, got unstable want stable");
        end
        get_report(1'b0, r, ok, st);
        checks++;
        if (!ok || r !== 64'h0) begin
            errors++;
            $display("FAIL toggle_release: got %h ok=%0d want 0", r, ok);
        end
    endtask

    task automatic test_fifo_full;
        logic [63:0] r, e;
        logic [7:0] em, ec;
        bit ok, st;
        ep_ready = 1'b0;
        push_ev(8'h05, 8'h20);
        key_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (ep_valid !== 1'b1 || ep_data !== 8'h05 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL full_stalled: ep_valid=%b ep_data=%h fifo_level=%0d want 1 05 0",
                     ep_valid, ep_data, fifo_level);
        end
        for (int i = 0; i < 6; i++) begin
            push_ev(8'(8'h10 + i), 8'(8'h21 + i));
        end
        key_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_level: fifo_level=%0d key_ready=%b want 4 0", fifo_level, key_ready);
        end
`ifdef USB_HID_KBD_STATS_EN
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL full_drop_cnt: got %0d want 2", drop_cnt);
        end
`endif
        ep_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            em = (i == 0) ? 8'h05 : 8'(8'h0F + i);
            ec = 8'(8'h20 + i);
            e  = {em, 8'h00, ec, 40'h0};
            get_report(1'b0, r, ok, st);
            checks++;
            if (!ok || r !== e) begin
                errors++;
                $display("FAIL full_drain_press_%0d: got %h ok=%0d want %h", i, r, ok, e);
            end
            get_report(1'b0, r, ok, st);
            checks++;
            if (!ok || r !== 64'h0) begin
                errors++;
                $display("FAIL full_drain_release_%0d: got %h ok=%0d want 0", i, r, ok);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (fifo_level !== 3'd0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_drained: fifo_level=%0d key_ready=%b want 0 1", fifo_level, key_ready);
        end
`ifdef USB_HID_KBD_STATS_EN
        checks++;
        if (report_cnt !== 16'd11) begin
            errors++;
            $display("FAIL report_cnt: got %0d want 11", report_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int guard;
        bit seen;
        ep_ready = 1'b1;
        push_ev(8'h03, 8'h08);
        push_ev(8'h04, 8'h09);
        key_valid = 1'b0;
        guard = 0;
        while (!ep_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (ep_valid !== 1'b1 || fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL mid_before_reset: ep_valid=%b fifo_level=%0d want 1 1", ep_valid, fifo_level);
        end
        usb_rstn = 1'b0;
        #1;
        checks++;
        if (ep_valid !== 1'b0 || fifo_level !== 3'd0 || ep_data !== 8'h00 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_reset: ep_valid=%b fifo_level=%0d ep_data=%h key_ready=%b want 0 0 00 1",
                     ep_valid, fifo_level, ep_data, key_ready);
        end
`ifdef USB_HID_KBD_STATS_EN
        checks++;
        if (report_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_stats_reset: report_cnt=%0d drop_cnt=%0d want 0 0", report_cnt, drop_cnt);
        end
`endif
        @(negedge clk);
        usb_rstn = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (ep_valid) seen = 1'b1;
        end
        checks++;
        if (seen || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL mid_no_release: ep_valid_seen=%0d fifo_level=%0d want 0 0", seen, fifo_level);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_batch();
        test_dup_and_modifier();
        test_stall_toggle();
        test_fifo_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_hid_kbd_report_gen.md
Name: usb_hid_kbd_report_gen

Overview:
Parametrised HID boot-keyboard report generator that sits between user logic and the IN endpoint 0x81 byte stream of the USB full-speed core.
- Key events (modifier plus keycode) are accepted through a valid/ready port and buffered in an internal FIFO.
- Up to NKEYS compatible events are batched into one 8-byte press report.
- Every press report is followed by an 8-byte all-zero release report.
- Adds event queueing, multi-key batching and configurable inter-report gaps over a single-key, one-shot generator.

Parameters:
FIFO_DEPTH, 8, key event queue depth; power of two, 2..64.
NKEYS, 6, max keycodes per press report, 1..6.
GAP_CYCLES, 1, cycles ep_valid is held low between consecutive reports, 1..255.

Ports:
clk  input  1  system clock (60 MHz domain of the USB core)
usb_rstn  input  1  asynchronous active-low reset
key_modifier  input  8  HID modifier bitmap of the offered event
key_code  input  8  HID usage keycode (0x00 = modifier-only event)
key_valid  input  1  event offered
key_ready  output  1  FIFO can accept; event pushed when key_valid && key_ready
fifo_level  output  $clog2(FIFO_DEPTH)+1  queued events
ep_data  output  8  report byte to endpoint 0x81
ep_valid  output  1  report byte valid; held high for all 8 bytes of one report
ep_ready  input  1  core consumed ep_data this cycle

Behaviour:
- Reset is usb_rstn, asynchronous, active-low; clock is clk. While reset is asserted:
  - FIFO is flushed and state is IDLE.
  - ep_valid=0, ep_data=0x00, fifo_level=0, key_ready=1.
- Reset mid-report aborts immediately. No release report is owed afterwards.
- FIFO:
  - key_ready = (fifo_level != FIFO_DEPTH), registered.
  - Push and pop in the same cycle is allowed; fifo_level is unchanged.
  - When full, key_ready=0 and offered events are not accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, GATHER, SEND_PRESS, GAP_P, SEND_REL, GAP_R.
- IDLE:
  - If the FIFO is non-empty, pop the head into batch slot 0, latch its modifier, and go to GATHER.
  - If the popped keycode is 0x00, the batch is closed and the next state is SEND_PRESS.
- GATHER pops at most one entry per cycle. It pops the head only when all of the following hold:
  - FIFO non-empty;
  - head modifier equals the latched modifier;
  - head keycode is not 0x00 and is not already in the batch;
  - batch count < NKEYS.
  Otherwise it goes to SEND_PRESS without popping. Non-matching entries remain queued in order.
- Press report byte order:
  - byte0 = modifier;
  - byte1 = 0x00;
  - bytes 2..7 = batched keycodes in pop order;
  - unused slots = 0x00.
- SEND_PRESS and SEND_REL:
  - ep_valid=1 with ep_data = current byte.
  - Byte index advances only on ep_valid && ep_ready.
  - After byte 7 is consumed, ep_valid drops in the next cycle.
  - ep_ready low stalls indefinitely with ep_data stable.
- GAP_P: ep_valid=0 for exactly GAP_CYCLES cycles, then SEND_REL.
- SEND_REL: sends 8 bytes of 0x00, then GAP_R.
- GAP_R: ep_valid=0 for GAP_CYCLES cycles, then IDLE.
- Latency: an event pushed at cycle t into an idle, empty block has ep_valid=1 no later than cycle t+4.
- ep_ready asserted while ep_valid=0 is ignored.

Optional Feature:
Macro USB_HID_KBD_STATS_EN.
- Defined:
  - Adds output report_cnt[15:0], incremented once per completed press report (byte 7 consumed). Wraps 0xFFFF->0x0000.
  - Adds output drop_cnt[15:0], incremented each cycle key_valid=1 && key_ready=0. Saturates at 0xFFFF.
  - Both counters reset to 0 on usb_rstn.
- Undefined: neither port exists and no counter logic is synthesised.

Test Plan:
1. Single event mod=0x02, code=0x04, ep_ready=1 -> ep_valid high within 4 cycles; bytes 02 00 04 00 00 00 00 00; 1 low cycle; 8x 00; fifo_level returns to 0.
2. Push codes 0x04, 0x05, 0x06 back-to-back with mod=0x00, NKEYS=6 -> one press report 00 00 04 05 06 00 00 00, then one release report.
3. Push 0x04, 0x04, then 0x07 with mod=0x01 -> report A is 00 00 04 ..; report B is 00 00 04 ..; report C is 01 00 07 ..; each followed by a zero release report.
4. FIFO_DEPTH=4 with ep_ready=0, offer 6 events -> key_ready=0 after 4 accepted events and fifo_level=4; with USB_HID_KBD_STATS_EN, drop_cnt counts the refused offer cycles.
5. ep_ready toggled 1-0-1 every cycle during a press report -> each byte is presented stable until consumed, with no byte lost or duplicated.
6. Assert usb_rstn=0 after byte 3 of a press report -> ep_valid=0 and fifo_level=0 the same cycle; after release, no release report is sent and the block is idle.
